stream_rr_arbiter: RTL
======================

// Module: stream_rr_arbiter
// PURPOSE
//  Per-output-port packet arbiter for the stream crossbar; one instance per master (output) port.
//  Selects one of S_DATA_COUNT requesting input streams by round-robin and locks that grant
//  until the packet's last beat has handshaken on the output, so packets are never interleaved.
//  The crossbar muxes data/last/valid/id and routes ready using grant_o/grant_id_o.
// PARAMETERS
//  S_DATA_COUNT  2  number of input streams (requesters); legal range 1..64
//  ID_W          derived: (S_DATA_COUNT>1) ? $clog2(S_DATA_COUNT) : 1; localparam, not overridable
// PORTS
//  clk         in   1             clock; all state updates on rising edge
//  rst_n       in   1             reset; asynchronous, active-low
//  req_i       in   S_DATA_COUNT  req_i[k] = s_valid_i[k] && (s_dest_i[k] == this port)
//  last_i      in   S_DATA_COUNT  s_last_i of each input stream
//  hs_i        in   1             output handshake of this port (m_valid_o && m_ready_i)
//  grant_o     out  S_DATA_COUNT  one-hot grant; all-zero when no packet owns the port
//  grant_id_o  out  ID_W          binary index of the granted input; drives m_id_o
//  busy_o      out  1             high while a packet owns the port (== |grant_o)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, grant_o=0, grant_id_o=0, busy_o=0, rr_ptr=0.
//  - All outputs are registered; no combinational path from req_i/hs_i to grant_o.
//  - FSM IDLE: if |req_i, pick first k with req_i[k]=1 searching rr_ptr, rr_ptr+1, ..., wrapping
//    at S_DATA_COUNT-1 -> 0; next cycle grant_o=1<<k, grant_id_o=k, busy_o=1, state=LOCKED.
//    Latency: request sampled at edge N, grant visible after edge N+1. No req -> stay IDLE.
//  - FSM LOCKED: grant held constant regardless of req_i (req drop mid-packet does NOT release).
//    Packet end = hs_i && last_i[grant_id_o]. On packet end: rr_ptr <= (grant_id_o+1) mod
//    S_DATA_COUNT; next state per CONFIGURATION. hs_i without last: no change.
//  - hs_i while IDLE is ignored (defensive; must not occur).
//  - Single-beat packet (last on first beat) ends the lock on that handshake edge.
//  - Fairness: after a packet from k, k has lowest priority; with all inputs requesting
//    continuously, grants cycle 0,1,...,S-1,0,...
//  - S_DATA_COUNT=1: grant_id_o constant 0; round-robin degenerates, FSM unchanged.
//  - Reset asserted mid-packet: grant dropped immediately (async), rr_ptr=0; the partial
//    packet is lost, with no recovery logic.
// CONFIGURATION
//  STREAM_ARB_FAST_SWITCH_EN
//   defined:   on packet end in LOCKED, arbitrate among req_i in the same cycle (same rr
//              search starting at the updated pointer (grant_id_o+1), so the finishing input is
//              searched last). If any req: the new grant is registered at that edge and the state
//              stays LOCKED (zero bubble). If none: go to IDLE with grant_o=0.
//   undefined: on packet end always go to IDLE with grant_o=0; at least one idle cycle
//              between consecutive packets on the port.
// TESTING
//  1 Reset: rst_n=0 with req_i=all ones -> grant_o=0, busy_o=0, grant_id_o=0; release,
//    req_i=2'b11 -> grant_o=2'b01 one cycle later.
//  2 Lock: grant to 0, 4-beat packet, req_i[1]=1 throughout, hs_i stalls randomly ->
//    grant_o stays 2'b01 until the 4th hs with last_i[0]=1; then 1 is granted.
//  3 Round-robin: S=3, req_i=3'b111 constantly, 1-beat packets -> grant_id_o sequence 0,1,2,0;
//    without FAST_SWITCH, busy_o=0 for exactly 1 cycle between grants.
//  4 FAST_SWITCH_EN: req_i=2'b11, last handshake on 0 -> grant_o goes 2'b01->2'b10 on the same
//    edge, busy_o never drops; only req_i[0] remains -> re-grant 0, no bubble.
//  5 Req drop: granted 1, req_i[1] deasserts mid-packet -> grant held until last_i[1]&&hs_i.
//  6 Async reset mid-packet: assert rst_n=0 between edges -> grant_o=0 before the next edge;
//    after release, rr_ptr=0 (req_i=2'b11 -> grant 0).

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Per-output-port round-robin packet arbiter: grants one requesting input and holds it until last beat.
// Optional zero-bubble re-arbitration on packet end via `define STREAM_ARB_FAST_SWITCH_EN.
module stream_rr_arbiter #(
  parameter int  S_DATA_COUNT = 2,
  localparam int ID_W = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_DATA_COUNT-1:0] req_i,
  input  logic [S_DATA_COUNT-1:0] last_i,
  input  logic                    hs_i,
  output logic [S_DATA_COUNT-1:0] grant_o,
  output logic [ID_W-1:0]         grant_id_o,
  output logic                    busy_o
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                  state_q, state_d;
  logic [S_DATA_COUNT-1:0] grant_d;
  logic [ID_W-1:0]         grant_id_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         ptr_inc;
  logic [ID_W-1:0]         search_start;
  logic [S_DATA_COUNT-1:0] req_rot;
  logic [ID_W-1:0]         pick_idx;
  logic                    pick_valid;
  logic                    pkt_end;
  int                      pick_sum;

  assign busy_o  = (state_q == LOCKED);
  assign pkt_end = busy_o && hs_i && (((last_i >> grant_id_o) & S_DATA_COUNT'(1)) != '0);
  assign ptr_inc = (grant_id_o == ID_W'(S_DATA_COUNT - 1)) ? '0 : grant_id_o + 1'b1;

  // While locked the only arbitration happens at packet end, starting just past the finisher.
  assign search_start = busy_o ? ptr_inc : rr_ptr_q;

  always_comb begin
    req_rot    = S_DATA_COUNT'({req_i, req_i} >> search_start);
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_sum   = 0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      if (!pick_valid && (((req_rot >> i) & S_DATA_COUNT'(1)) != '0)) begin
        pick_valid = 1'b1;
        pick_sum   = int'(search_start) + i;
        if (pick_sum >= S_DATA_COUNT) pick_sum = pick_sum - S_DATA_COUNT;
        pick_idx   = ID_W'(pick_sum);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_o;
    grant_id_d = grant_id_o;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = LOCKED;
          grant_d    = S_DATA_COUNT'(1) << pick_idx;
          grant_id_d = pick_idx;
        end
      end
      LOCKED: begin
        if (pkt_end) begin
          rr_ptr_d = ptr_inc;
`ifdef STREAM_ARB_FAST_SWITCH_EN
          if (pick_valid) begin
            grant_d    = S_DATA_COUNT'(1) << pick_idx;
            grant_id_d = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
`else
          state_d = IDLE;
          grant_d = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_o    <= '0;
      grant_id_o <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_o    <= grant_d;
      grant_id_o <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule
